// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!valid && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Optional FIFO_ARB_STATS_EN adds per-producer saturating accepted-word counters (beat_count).
//
// state | meaning
// IDLE  | no grant; waiting for any req
// BURST | one producer granted; up to MAX_BURST words accepted
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_full
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     beat_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;

  logic [PTR_W-1:0]   gidx, nxt_ptr, pick_ptr;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic               granted_req, accept, last_beat, release_burst;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gidx = PTR_W'(i);
  end

  assign nxt_ptr       = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign granted_req   = |(gnt & req);
  assign accept        = (state == BURST) && granted_req && !fifo_full;
  assign last_beat     = accept && (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign release_burst = (state == BURST) && (last_beat || !granted_req);

  // During a burst the selector already looks past the current owner, so a
  // release can hand over on the same edge without an idle cycle.
  assign pick_ptr = (state == BURST) ? nxt_ptr : rr_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (pick_ptr),
    .pick   (pick),
    .valid  (pick_valid)
  );

  assign fifo_wr_en = accept;
  assign ack        = accept ? gnt : '0;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (accept && gnt[i]) fifo_data_in = wdata[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n    = BURST;
          gnt_n      = pick;
          beat_cnt_n = '0;
        end
      end
      BURST: begin
        if (release_burst) begin
          rr_ptr_n   = nxt_ptr;
          beat_cnt_n = '0;
          if (pick_valid) begin
            gnt_n = pick;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (accept) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        stat_q[i] <= '0;
      else if (ack[i] && stat_q[i] != 16'hFFFF)
        stat_q[i] <= stat_q[i] + 16'd1;
    end
    assign beat_count[i*16 +: 16] = stat_q[i];
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producers sharing one sync FIFO write port.
REQ-002 Parameter DATA_W, default 8: word width; matches the FIFO data_in width.
REQ-003 Parameter MAX_BURST, default 4: maximum words accepted per grant; legal range 1..15.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port req  input  NUM_REQ: per-producer request; held high while the producer has a word presented.
REQ-007 Port wdata  input  NUM_REQ*DATA_W: producer i word on bits [i*DATA_W +: DATA_W].
REQ-008 Port gnt  output  NUM_REQ: registered grant, one-hot or zero.
REQ-009 Port ack  output  NUM_REQ: combinational, one-hot; the presented word was written this cycle.
REQ-010 Port fifo_wr_en  output  1: FIFO write strobe.
REQ-011 Port fifo_data_in  output  DATA_W: FIFO write data.
REQ-012 Port fifo_full  input  1: FIFO full flag.

Function
REQ-013 State machine SHALL have two states, IDLE and BURST; IDLE has gnt=0.
REQ-014 IDLE: if any req is high at a rising edge, the block SHALL grant the first requesting index at or after rr_ptr (wrapping modulo NUM_REQ), enter BURST and clear beat_cnt.
REQ-015 Accept condition SHALL be gnt[i] & req[i] & ~fifo_full, giving fifo_wr_en=1, ack[i]=1 and fifo_data_in=wdata slice i in the same cycle.
REQ-016 When fifo_wr_en=0, fifo_data_in SHALL be 0.
REQ-017 Latency SHALL be one cycle: req rising before edge t gives gnt at t, and the first write occurs in the cycle after t if the FIFO is not full.
REQ-018 Each accept SHALL increment beat_cnt (width clog2(MAX_BURST+1)).
REQ-019 Release SHALL occur at the edge ending a cycle in which the MAX_BURST-th accept occurs, or in which the granted req is low.
REQ-020 At release, rr_ptr SHALL become granted index+1 modulo NUM_REQ.
REQ-021 At release, if any req is high, the block SHALL grant the next requester from the new rr_ptr (back-to-back, no idle cycle; the same requester is re-granted if it is the only requester); otherwise it SHALL go to IDLE.
REQ-022 While fifo_full=1: no write, no beat count, grant held indefinitely, no timeout.
REQ-023 Requests from non-granted producers SHALL never produce ack or fifo_wr_en.

Reset
REQ-024 On rst: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0; hence ack=0 and fifo_wr_en=0 immediately.
REQ-025 Reset mid-burst SHALL abandon the burst; after reset deasserts, arbitration restarts from index 0.

Configuration
REQ-026 With macro FIFO_ARB_STATS_EN defined, an output port beat_count (NUM_REQ*16) SHALL exist, holding per-producer saturating (at 16'hFFFF) counts of accepted words, cleared by rst.
REQ-027 Without FIFO_ARB_STATS_EN, the beat_count port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default NUM_REQ, DATA_W and MAX_BURST constants.
REQ-029 Sub-module rr_pick SHALL be the combinational round-robin selector: inputs req and rr_ptr; output one-hot pick and valid.

Verification (NUM_REQ=4, MAX_BURST=4, DATA_W=8, connected to sync_fifo depth 8)
REQ-030 Single producer: req[2] held with 8 words 0x01..0x08 -> gnt=4'b0100; two bursts of 4 separated by a re-grant edge with no gap; FIFO receives 01..08 in order.
REQ-031 All four producers requesting continuously -> grant order 0,1,2,3,0, with 4 acks per grant and 16 acks per full round.
REQ-032 FIFO fills mid-burst (fifo_full=1 after the 8th write) -> fifo_wr_en=0, gnt held and beat_cnt frozen; one read clears full and the write resumes with the next word.
REQ-033 Producer 1 drops req after 2 words while req[3] is pending -> next edge gives gnt=4'b1000 and rr_ptr=2.
REQ-034 rst asserted mid-burst -> gnt, ack and fifo_wr_en go 0 without waiting for a clock edge; after release, req=4'b1010 gives gnt=4'b0010.
REQ-035 Built with FIFO_ARB_STATS_EN, run REQ-031 for 2 rounds -> beat_count=8 for each producer.
